// File: rtl/clk_div_monitor.sv
// Synchronises a divided clock into clk, measures each high/low phase and
// checks them against expected lengths, reporting errors, a period count and lock.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ACQUIRE   | waiting for the first synchronised rise; partial periods dropped
//   MEAS_HIGH | timing the high phase, captured into high_len on the fall
//   MEAS_LOW  | timing the low phase, captured into low_len and checked on the rise
module clk_div_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int EXP_HIGH    = 3,
    parameter int EXP_LOW     = 3,
    parameter int LOCK_CNT    = 4,
    parameter int PCNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              div_in,
    input  logic              err_clr,
    output logic              rise_pulse,
    output logic              fall_pulse,
    output logic [CNT_W-1:0]  high_len,
    output logic [CNT_W-1:0]  low_len,
    output logic              len_valid,
    output logic              err,
    output logic              err_sticky,
    output logic              locked,
    output logic [PCNT_W-1:0] period_count
);

    typedef enum logic [1:0] {
        ACQUIRE   = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] RUN_MAX  = '1;
    localparam logic [CNT_W-1:0] EXP_H    = CNT_W'(EXP_HIGH);
    localparam logic [CNT_W-1:0] EXP_L    = CNT_W'(EXP_LOW);
    localparam logic [3:0]       LOCK_VAL = 4'(LOCK_CNT);

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_lvl;
    logic                   rise_cond;
    logic                   fall_cond;
    logic [CNT_W-1:0]       run_cnt;
    logic                   run_sat;
    logic [3:0]             good_cnt;
    logic                   cap_high;
    logic                   cap_low;
    logic                   period_done;
    logic                   period_bad;

    assign sync_lvl  = sync_q[SYNC_STAGES-1];
    assign rise_cond = sync_lvl & ~hist_q;
    assign fall_cond = ~sync_lvl & hist_q;
    assign run_sat   = (run_cnt == RUN_MAX);
    assign locked    = (good_cnt == LOCK_VAL);

    // The synchroniser and run counter keep running while disabled so that
    // re-enabling never sees a stale level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            hist_q  <= 1'b0;
            run_cnt <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], div_in};
            hist_q <= sync_lvl;
            if (rise_cond || fall_cond) begin
                run_cnt <= CNT_W'(1);
            end else if (!run_sat) begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACQUIRE;
        end else begin
            state <= state_next;
        end
    end

    // Saturation takes priority over an edge in the same cycle: the phase is
    // already too long to be trusted.
    always_comb begin
        state_next  = state;
        cap_high    = 1'b0;
        cap_low     = 1'b0;
        period_done = 1'b0;
        period_bad  = 1'b0;
        if (!en) begin
            state_next = ACQUIRE;
        end else begin
            unique case (state)
                ACQUIRE: begin
                    if (rise_cond) begin
                        state_next = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (run_sat) begin
                        period_bad = 1'b1;
                        state_next = ACQUIRE;
                    end else if (fall_cond) begin
                        cap_high   = 1'b1;
                        state_next = MEAS_LOW;
                    end
                end
                MEAS_LOW: begin
                    if (run_sat) begin
                        period_bad = 1'b1;
                        state_next = ACQUIRE;
                    end else if (rise_cond) begin
                        cap_low     = 1'b1;
                        period_done = 1'b1;
                        state_next  = MEAS_HIGH;
                        if ((high_len != EXP_H) || (run_cnt != EXP_L)) begin
                            period_bad = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = ACQUIRE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            high_len     <= '0;
            low_len      <= '0;
            len_valid    <= 1'b0;
            err          <= 1'b0;
            err_sticky   <= 1'b0;
            good_cnt     <= '0;
            period_count <= '0;
        end else begin
            rise_pulse <= rise_cond & en;
            fall_pulse <= fall_cond & en;
            len_valid  <= period_done;
            err        <= period_bad;
            if (cap_high) begin
                high_len <= run_cnt;
            end
            if (cap_low) begin
                low_len <= run_cnt;
            end
            if (period_done) begin
                period_count <= period_count + PCNT_W'(1);
            end
            if (!en || period_bad) begin
                good_cnt <= '0;
            end else if (period_done && (good_cnt != LOCK_VAL)) begin
                good_cnt <= good_cnt + 4'd1;
            end
            // A new error outranks a simultaneous clear.
            if (period_bad) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: a phase-level model predicts every
// len_valid/err event, and a negedge monitor compares the DUT against it.
module tb_clk_div_monitor;

    localparam int M_ACQ = 0;
    localparam int M_HI  = 1;
    localparam int M_LO  = 2;

    typedef struct {
        logic       tmo;
        logic [7:0] hi;
        logic [7:0] lo;
        logic       e;
        logic       lk;
        logic [3:0] pc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       div_in;
    logic       err_clr;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic       len_valid;
    logic       err;
    logic       err_sticky;
    logic       locked;
    logic [3:0] period_count;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    exp_t got;

    int         m_state = M_ACQ;
    logic [7:0] m_high  = '0;
    int         m_good  = 0;
    logic [3:0] m_pc    = '0;
    logic       cur_lvl = 1'b0;
    int         cur_len = 0;

    clk_div_monitor #(.PCNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .div_in       (div_in),
        .err_clr      (err_clr),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .high_len     (high_len),
        .low_len      (low_len),
        .len_valid    (len_valid),
        .err          (err),
        .err_sticky   (err_sticky),
        .locked       (locked),
        .period_count (period_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    task automatic model_edge(input logic lvl, input int len);
        exp_t r;
        case (m_state)
            M_ACQ: if (lvl) m_state = M_HI;
            M_HI: if (!lvl) begin
                m_high  = 8'(len);
                m_state = M_LO;
            end
            M_LO: if (lvl) begin
                m_pc   = m_pc + 4'd1;
                r.tmo  = 1'b0;
                r.hi   = m_high;
                r.lo   = 8'(len);
                r.e    = (m_high != 8'd3) || (len != 3);
                m_good = r.e ? 0 : ((m_good == 4) ? 4 : m_good + 1);
                r.lk   = (m_good == 4);
                r.pc   = m_pc;
                sb_q.push_back(r);
                m_state = M_HI;
            end
            default: m_state = M_ACQ;
        endcase
    endtask

    task automatic set_level(input logic lvl);
        if (lvl != cur_lvl) begin
            model_edge(lvl, cur_len);
            cur_lvl = lvl;
            cur_len = 0;
        end
        div_in = lvl;
    endtask

    task automatic wait_cycles(input int n);
        exp_t r;
        if (m_state != M_ACQ && cur_len + n >= 256) begin
            r.tmo  = 1'b1;
            r.hi   = '0;
            r.lo   = '0;
            r.e    = 1'b1;
            r.lk   = 1'b0;
            r.pc   = m_pc;
            sb_q.push_back(r);
            m_state = M_ACQ;
            m_good  = 0;
        end
        cur_len += n;
        repeat (n) @(negedge clk);
    endtask

    task automatic period(input int h, input int l);
        set_level(1'b1);
        wait_cycles(h);
        set_level(1'b0);
        wait_cycles(l);
    endtask

    always @(negedge clk) begin
        if (rst && (len_valid || err)) begin
            check("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                got = sb_q.pop_front();
                if (got.tmo) begin
                    check("tmo_len_valid", len_valid, 0);
                    check("tmo_err", err, 1);
                    check("tmo_locked", locked, 0);
                    check("tmo_pcount", period_count, got.pc);
                end else begin
                    check("len_valid", len_valid, 1);
                    check("rise_with_lv", rise_pulse, 1);
                    check("err", err, got.e);
                    check("high_len", high_len, got.hi);
                    check("low_len", low_len, got.lo);
                    check("locked", locked, got.lk);
                    check("period_count", period_count, got.pc);
                end
            end
        end
    end

    initial begin
        rst     = 1'b0;
        en      = 1'b1;
        div_in  = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rise", rise_pulse, 0);
        check("rst_len_valid", len_valid, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_locked", locked, 0);
        check("rst_pcount", period_count, 0);
        rst = 1'b1;
        wait_cycles(5);

        // good by-6 clock, with edge-strobe latency checked on the first rise
        set_level(1'b1);
        wait_cycles(2);
        check("rise_lat_early", rise_pulse, 0);
        wait_cycles(1);
        check("rise_lat", rise_pulse, 1);
        set_level(1'b0);
        wait_cycles(3);
        repeat (17) period(3, 3);
        check("locked_good", locked, 1);
        check("sticky_good", err_sticky, 0);

        // short high phase; err_clr coincident with the error, then one cycle later
        period(2, 3);
        set_level(1'b1);
        wait_cycles(2);
        err_clr = 1'b1;
        wait_cycles(1);
        check("sticky_set_wins", err_sticky, 1);
        set_level(1'b0);
        wait_cycles(1);
        check("sticky_cleared", err_sticky, 0);
        err_clr = 1'b0;
        wait_cycles(2);
        repeat (5) period(3, 3);
        check("relocked", locked, 1);

        // stuck high: timeout, then re-acquire
        set_level(1'b1);
        wait_cycles(300);
        set_level(1'b0);
        wait_cycles(3);
        repeat (3) period(3, 3);
        check("sticky_tmo", err_sticky, 1);

        // enable dropped mid low phase
        set_level(1'b1);
        wait_cycles(3);
        set_level(1'b0);
        wait_cycles(4);
        en      = 1'b0;
        m_state = M_ACQ;
        m_good  = 0;
        wait_cycles(2);
        check("en_locked", locked, 0);
        check("en_pcount_hold", period_count, m_pc);
        check("en_sticky_hold", err_sticky, 1);
        en = 1'b1;
        wait_cycles(4);
        repeat (5) period(3, 3);
        check("locked_after_en", locked, 32'(m_good == 4));

        // reset in the middle of a low phase
        set_level(1'b1);
        wait_cycles(3);
        set_level(1'b0);
        wait_cycles(4);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_high_len", high_len, 0);
        check("mid_rst_low_len", low_len, 0);
        check("mid_rst_fall", fall_pulse, 0);
        check("mid_rst_sticky", err_sticky, 0);
        check("mid_rst_pcount", period_count, 0);
        sb_q.delete();
        m_state = M_ACQ;
        m_good  = 0;
        m_pc    = '0;
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(4);
        repeat (3) period(3, 3);
        check("post_rst_pcount", period_count, 2);

        wait_cycles(10);
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
